// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage
// Decode-to-execute pipeline register for the vector datapath, built as a
// two-entry skid buffer. Execute back-pressure is absorbed by the skid entry,
// so in_ready depends only on registered state, never on out_ready.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   flush             synchronous kill of every buffered and incoming entry
//   in_valid/in_ready decode-side handshake
//   rd1, rd2, extend  LANES*N operand vectors
//   ra1, ra2, wa3     register addresses
//   ctrl              {FlagWrite, ALUSrc, Branch, MemWrite, MemtoReg, RegWrite, PCSrc}
//   alu_control       ALU operation
//   out_valid/out_ready execute-side handshake
//   *_o               registered payload from the main entry (ctrl_o gated)
//   stall_cnt         saturating count of back-pressured cycles
//
// state | meaning ({s_valid, m_valid})
//   EMPTY | no entries held
//   HALF  | main entry valid, skid entry empty
//   FULL  | main and skid entries valid, in_ready low
//   BAD   | skid valid without main; unreachable, recovers to EMPTY
module id_ex_skid_stage #(
  parameter int LANES  = 3,
  parameter int N      = 18,
  parameter int RA_W   = 4,
  parameter int ALUC_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*N-1:0]    rd1,
  input  logic [LANES*N-1:0]    rd2,
  input  logic [LANES*N-1:0]    extend,
  input  logic [RA_W-1:0]       ra1,
  input  logic [RA_W-1:0]       ra2,
  input  logic [RA_W-1:0]       wa3,
  input  logic [6:0]            ctrl,
  input  logic [ALUC_W-1:0]     alu_control,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*N-1:0]    rd1_o,
  output logic [LANES*N-1:0]    rd2_o,
  output logic [LANES*N-1:0]    extend_o,
  output logic [RA_W-1:0]       ra1_o,
  output logic [RA_W-1:0]       ra2_o,
  output logic [RA_W-1:0]       wa3_o,
  output logic [6:0]            ctrl_o,
  output logic [ALUC_W-1:0]     alu_control_o,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int VW = LANES * N;
  localparam int PW = 3 * VW + 3 * RA_W + 7 + ALUC_W;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    BAD   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     m_pay_q, m_pay_d;
  logic [PW-1:0]     s_pay_q, s_pay_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              m_valid, s_valid;
  logic              acc, fire;
  logic [PW-1:0]     in_pay;
  logic [6:0]        ctrl_m;

  assign m_valid   = state_q[0];
  assign s_valid   = state_q[1];
  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign acc       = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  assign in_pay = {rd1, rd2, extend, ra1, ra2, wa3, ctrl, alu_control};

  always_comb begin
    state_d = state_q;
    m_pay_d = m_pay_q;
    s_pay_d = s_pay_q;
    if (flush) begin
      // payload left untouched; the gated ctrl_o makes it harmless
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            m_pay_d = in_pay;
            state_d = HALF;
          end
        end
        HALF: begin
          if (acc && fire) begin
            m_pay_d = in_pay;
          end else if (acc) begin
            s_pay_d = in_pay;
            state_d = FULL;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            m_pay_d = s_pay_q;
            state_d = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      m_pay_q     <= '0;
      s_pay_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_pay_q     <= m_pay_d;
      s_pay_q     <= s_pay_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign {rd1_o, rd2_o, extend_o, ra1_o, ra2_o, wa3_o, ctrl_m, alu_control_o} = m_pay_q;

  // invalid cycles present as bubbles with no control side effects
  assign ctrl_o    = m_valid ? ctrl_m : 7'b0;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
module tb_id_ex_skid_stage;

  // DUT A: default build
  logic        clk;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [53:0] rd1, rd2, extend, rd1_o, rd2_o, extend_o;
  logic [3:0]  ra1, ra2, wa3, ra1_o, ra2_o, wa3_o;
  logic [6:0]  ctrl, ctrl_o;
  logic [3:0]  alu_control, alu_control_o;
  logic [15:0] stall_cnt;

  // DUT B: LANES=4, N=16, CNT_W=4
  logic        b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_rd1, b_rd2, b_extend, b_rd1_o, b_rd2_o, b_extend_o;
  logic [3:0]  b_ra1, b_ra2, b_wa3, b_ra1_o, b_ra2_o, b_wa3_o;
  logic [6:0]  b_ctrl, b_ctrl_o;
  logic [3:0]  b_alu, b_alu_o;
  logic [3:0]  b_stall_cnt;

  int n_chk;
  int n_pass;

  logic [214:0] sb[$];

  id_ex_skid_stage dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd1(rd1), .rd2(rd2), .extend(extend),
    .ra1(ra1), .ra2(ra2), .wa3(wa3),
    .ctrl(ctrl), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd1_o(rd1_o), .rd2_o(rd2_o), .extend_o(extend_o),
    .ra1_o(ra1_o), .ra2_o(ra2_o), .wa3_o(wa3_o),
    .ctrl_o(ctrl_o), .alu_control_o(alu_control_o),
    .stall_cnt(stall_cnt)
  );

  id_ex_skid_stage #(.LANES(4), .N(16), .RA_W(4), .ALUC_W(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(b_reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rd1(b_rd1), .rd2(b_rd2), .extend(b_extend),
    .ra1(b_ra1), .ra2(b_ra2), .wa3(b_wa3),
    .ctrl(b_ctrl), .alu_control(b_alu),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .rd1_o(b_rd1_o), .rd2_o(b_rd2_o), .extend_o(b_extend_o),
    .ra1_o(b_ra1_o), .ra2_o(b_ra2_o), .wa3_o(b_wa3_o),
    .ctrl_o(b_ctrl_o), .alu_control_o(b_alu_o),
    .stall_cnt(b_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [53:0] pat_rd1(input int k);
    return {18'(k + 1), 18'(k + 2), 18'(k + 3)};
  endfunction
  function automatic logic [53:0] pat_rd2(input int k);
    return {18'(k * 7), 18'(k * 11), 18'(18'h3ffff - k)};
  endfunction
  function automatic logic [6:0] pat_ctrl(input int k);
    return 7'(k * 5 + 2);
  endfunction
  function automatic logic [3:0] pat_wa3(input int k);
    return 4'(k + 7);
  endfunction

  task automatic drive_a(input int k);
    in_valid    = 1'b1;
    rd1         = pat_rd1(k);
    rd2         = pat_rd2(k);
    extend      = {18'(k), 18'(k ^ 5), 18'(k << 3)};
    ra1         = 4'(k);
    ra2         = 4'(k + 3);
    wa3         = pat_wa3(k);
    ctrl        = pat_ctrl(k);
    alu_control = 4'(k * 3 + 1);
  endtask

  // one scoreboarded cycle on DUT B: inputs already driven, edge not yet taken
  task automatic sb_cycle();
    logic [214:0] e;
    if (b_out_valid && b_out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 128'(1), 128'(0));
      end else begin
        e = sb.pop_front();
        chk("sb_rd1",    128'(b_rd1_o),    128'(e[214:151]));
        chk("sb_rd2",    128'(b_rd2_o),    128'(e[150:87]));
        chk("sb_extend", 128'(b_extend_o), 128'(e[86:23]));
        chk("sb_addr",   128'({b_ra1_o, b_ra2_o, b_wa3_o}), 128'(e[22:11]));
        chk("sb_ctl",    128'({b_ctrl_o, b_alu_o}), 128'(e[10:0]));
      end
    end
    if (b_in_valid && b_in_ready)
      sb.push_back({b_rd1, b_rd2, b_extend, b_ra1, b_ra2, b_wa3, b_ctrl, b_alu});
    step();
  endtask

  task automatic rand_b(input bit v);
    b_in_valid = v;
    b_rd1      = {$urandom, $urandom};
    b_rd2      = {$urandom, $urandom};
    b_extend   = {$urandom, $urandom};
    b_ra1      = 4'($urandom);
    b_ra2      = 4'($urandom);
    b_wa3      = 4'($urandom);
    b_ctrl     = 7'($urandom);
    b_alu      = 4'($urandom);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rd1 = '0; rd2 = '0; extend = '0; ra1 = '0; ra2 = '0; wa3 = '0;
    ctrl = '0; alu_control = '0;
    b_reset = 1'b1; b_flush = 1'b0; b_out_ready = 1'b0;
    rand_b(1'b0);

    #3;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_rd1_o",     128'(rd1_o),     128'(0));
    chk("rst_ctrl_o",    128'(ctrl_o),    128'(0));
    chk("rst_stall",     128'(stall_cnt), 128'(0));
    step();
    reset = 1'b0;
    b_reset = 1'b0;

    // first entry, one-cycle latency
    drive_a(0);
    out_ready = 1'b1;
    step();
    chk("t1_out_valid", 128'(out_valid), 128'(1));
    chk("t1_rd1_o",     128'(rd1_o), 128'({18'h1, 18'h2, 18'h3}));
    chk("t1_ctrl_o",    128'(ctrl_o), 128'(7'h02));

    // eight-entry stream at full throughput
    for (int i = 1; i <= 8; i++) begin
      drive_a(i);
      step();
      chk("stream_valid", 128'(out_valid), 128'(1));
      chk("stream_rd1",   128'(rd1_o), 128'(pat_rd1(i)));
      chk("stream_wa3",   128'(wa3_o), 128'(pat_wa3(i)));
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid",   128'(out_valid), 128'(0));
    chk("drain_ctrl_o",  128'(ctrl_o), 128'(0));
    chk("drain_rd1_hold",128'(rd1_o), 128'(pat_rd1(8)));
    chk("drain_stall",   128'(stall_cnt), 128'(0));

    // back-pressure: A then B fill the buffer
    out_ready = 1'b0;
    drive_a(20);
    step();
    chk("bp_a_valid", 128'(out_valid), 128'(1));
    chk("bp_a_ready", 128'(in_ready), 128'(1));
    drive_a(21);
    step();
    chk("bp_full_ready", 128'(in_ready), 128'(0));
    chk("bp_full_rd1",   128'(rd1_o), 128'(pat_rd1(20)));
    in_valid = 1'b0;
    repeat (3) step();
    chk("bp_hold_rd1",  128'(rd1_o), 128'(pat_rd1(20)));
    chk("bp_hold_rd2",  128'(rd2_o), 128'(pat_rd2(20)));
    chk("bp_stall",     128'(stall_cnt), 128'(4));
    out_ready = 1'b1;
    step();
    chk("bp_b_valid", 128'(out_valid), 128'(1));
    chk("bp_b_rd1",   128'(rd1_o), 128'(pat_rd1(21)));
    chk("bp_b_ctrl",  128'(ctrl_o), 128'(pat_ctrl(21)));
    chk("bp_b_ready", 128'(in_ready), 128'(1));
    step();
    chk("bp_empty",   128'(out_valid), 128'(0));
    chk("bp_stall2",  128'(stall_cnt), 128'(4));

    // flush while FULL, with an input offered
    out_ready = 1'b0;
    drive_a(22);
    step();
    drive_a(23);
    step();
    chk("fl_full_ready", 128'(in_ready), 128'(0));
    drive_a(24);
    flush = 1'b1;
    step();
    chk("fl_out_valid", 128'(out_valid), 128'(0));
    chk("fl_in_ready",  128'(in_ready), 128'(1));
    chk("fl_ctrl_o",    128'(ctrl_o), 128'(0));
    chk("fl_stall",     128'(stall_cnt), 128'(5));
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_no_ghost", 128'(out_valid), 128'(0));

    // flush while HALF discards a concurrent accept
    out_ready = 1'b0;
    drive_a(25);
    step();
    chk("flh_valid", 128'(out_valid), 128'(1));
    drive_a(26);
    flush = 1'b1;
    step();
    chk("flh_out_valid", 128'(out_valid), 128'(0));
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("flh_no_ghost", 128'(out_valid), 128'(0));
    chk("flh_stall",    128'(stall_cnt), 128'(5));

    // normal flow resumes, then fill and reset asynchronously mid-cycle
    out_ready = 1'b1;
    drive_a(27);
    step();
    chk("rs_h_rd1", 128'(rd1_o), 128'(pat_rd1(27)));
    out_ready = 1'b0;
    drive_a(28);
    step();
    in_valid = 1'b0;
    chk("rs_full_ready", 128'(in_ready), 128'(0));
    chk("rs_stall",      128'(stall_cnt), 128'(6));
    #2;
    reset = 1'b1;
    #1;
    chk("ar_out_valid", 128'(out_valid), 128'(0));
    chk("ar_in_ready",  128'(in_ready), 128'(1));
    chk("ar_rd1_o",     128'(rd1_o), 128'(0));
    chk("ar_wa3_o",     128'(wa3_o), 128'(0));
    chk("ar_ctrl_o",    128'(ctrl_o), 128'(0));
    chk("ar_alu_o",     128'(alu_control_o), 128'(0));
    chk("ar_stall",     128'(stall_cnt), 128'(0));
    step();
    reset = 1'b0;

    // DUT B: stall counter saturation at 15
    b_out_ready = 1'b0;
    rand_b(1'b1);
    step();
    b_in_valid = 1'b0;
    chk("sat_start", 128'(b_stall_cnt), 128'(0));
    repeat (10) step();
    chk("sat_mid", 128'(b_stall_cnt), 128'(10));
    repeat (10) step();
    chk("sat_top",   128'(b_stall_cnt), 128'(15));
    chk("sat_valid", 128'(b_out_valid), 128'(1));
    #2;
    b_reset = 1'b1;
    #1;
    chk("sat_rst", 128'(b_stall_cnt), 128'(0));
    step();
    b_reset = 1'b0;

    // DUT B: random traffic against an in-order scoreboard
    for (int i = 0; i < 300; i++) begin
      rand_b(1'($urandom_range(0, 1)));
      b_out_ready = ($urandom_range(0, 3) != 0);
      sb_cycle();
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    repeat (4) sb_cycle();
    chk("sb_drained", 128'(sb.size()), 128'(0));
    chk("sb_out_valid", 128'(b_out_valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
